// File: rtl/hamming_encoder.sv
// Multi-cycle SECDED (32,26) Hamming encoder: one parity bit per CALC cycle, overall parity in OVALL.
// Optional HAMMING_ENC_ERR_INJECT_EN adds an err_mask port that corrupts encoded_data for decoder testing.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | scatter latched payload into work register
// CALC  | compute parity p(2^idx), idx = 0..4
// OVALL | overall parity, register outputs, raise done
// DONE  | done pulse cycle; start here chains straight into LOAD

module hamming_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [25:0] data_in,
  input  logic        start,
`ifdef HAMMING_ENC_ERR_INJECT_EN
  input  logic [31:0] err_mask,
`endif
  output logic [31:0] encoded_data,
  output logic [5:0]  parity_bits,
  output logic        done,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CALC  = 3'd2,
    OVALL = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [25:0] data_q, data_d;
  logic [31:0] work_q, work_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] enc_q, enc_d;
  logic [5:0]  par_q, par_d;
  logic        done_q, done_d;
  logic [4:0]  ppos;
  logic [31:0] clean_cw;
`ifdef HAMMING_ENC_ERR_INJECT_EN
  logic [31:0] err_mask_q, err_mask_d;
`endif

  // Positions covered by parity p(2^j): index bit j set, parity position itself excluded.
  function automatic logic [31:0] parity_mask(input logic [2:0] j);
    logic [31:0] m;
    logic [4:0]  pos;
    m = '0;
    for (int i = 1; i < 32; i++) begin
      pos = i[4:0];
      if (pos[j] && (pos != (5'd1 << j)))
        m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [31:0] place_data(input logic [25:0] d);
    logic [31:0] w;
    int k;
    w = '0;
    k = 0;
    for (int i = 1; i < 32; i++) begin
      if ((i & (i - 1)) != 0) begin
        w[i] = d[k[4:0]];
        k++;
      end
    end
    return w;
  endfunction

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    work_d   = work_q;
    idx_d    = idx_q;
    enc_d    = enc_q;
    par_d    = par_q;
    done_d   = 1'b0;
    ppos     = 5'd1 << idx_q;
    clean_cw = {work_q[31:1], ^work_q[31:1]};
`ifdef HAMMING_ENC_ERR_INJECT_EN
    err_mask_d = err_mask_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          data_d  = data_in;
          idx_d   = 3'd0;
          state_d = LOAD;
`ifdef HAMMING_ENC_ERR_INJECT_EN
          err_mask_d = err_mask;
`endif
        end
      end
      LOAD: begin
        work_d  = place_data(data_q);
        state_d = CALC;
      end
      CALC: begin
        work_d[ppos] = ^(work_q & parity_mask(idx_q));
        if (idx_q == 3'd4)
          state_d = OVALL;
        else
          idx_d = idx_q + 3'd1;
      end
      OVALL: begin
`ifdef HAMMING_ENC_ERR_INJECT_EN
        enc_d = clean_cw ^ err_mask_q;
`else
        enc_d = clean_cw;
`endif
        par_d   = {clean_cw[0], work_q[16], work_q[8], work_q[4], work_q[2], work_q[1]};
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      work_q  <= '0;
      idx_q   <= '0;
      enc_q   <= '0;
      par_q   <= '0;
      done_q  <= 1'b0;
`ifdef HAMMING_ENC_ERR_INJECT_EN
      err_mask_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      work_q  <= work_d;
      idx_q   <= idx_d;
      enc_q   <= enc_d;
      par_q   <= par_d;
      done_q  <= done_d;
`ifdef HAMMING_ENC_ERR_INJECT_EN
      err_mask_q <= err_mask_d;
`endif
    end
  end

  assign encoded_data = enc_q;
  assign parity_bits  = par_q;
  assign done         = done_q;
  assign busy         = (state_q == LOAD) || (state_q == CALC) || (state_q == OVALL);

endmodule

// File: tb/tb_hamming_encoder.sv
// Bench for hamming_encoder: vector table plus scoreboard checked on each done pulse.
// Define HAMMING_ENC_ERR_INJECT_EN to also exercise the err_mask path.

module tb_hamming_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [25:0] data_in;
  logic        start;
  logic [31:0] encoded_data;
  logic [5:0]  parity_bits;
  logic        done;
  logic        busy;
`ifdef HAMMING_ENC_ERR_INJECT_EN
  logic [31:0] err_mask;
`endif

  hamming_encoder dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .start(start),
`ifdef HAMMING_ENC_ERR_INJECT_EN
    .err_mask(err_mask),
`endif
    .encoded_data(encoded_data),
    .parity_bits(parity_bits),
    .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] data;
    logic [31:0] enc;
    logic [5:0]  par;
  } vec_t;

  typedef struct {
    logic [31:0] enc;
    logic [5:0]  par;
    int          acc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   done_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: parity bits equal the XOR of the positions of all set data bits.
  function automatic logic [31:0] model_cw(input logic [25:0] d);
    logic [31:0] cw;
    logic [4:0]  syn;
    int          k;
    cw = '0;
    syn = '0;
    k = 0;
    for (int pos = 1; pos < 32; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[k];
        if (d[k]) syn ^= pos[4:0];
        k++;
      end
    end
    for (int j = 0; j < 5; j++) cw[1 << j] = syn[j];
    cw[0] = ^cw[31:1];
    return cw;
  endfunction

  function automatic logic [5:0] model_par(input logic [31:0] cw);
    return {cw[0], cw[16], cw[8], cw[4], cw[2], cw[1]};
  endfunction

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_count++;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("encoded_data", encoded_data, e.enc);
        check("parity_bits", {26'd0, parity_bits}, {26'd0, e.par});
        check("latency", cyc - e.acc, 8);
      end
    end
  end

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic start_enc(input logic [25:0] d, input logic [31:0] m,
                           input logic [31:0] exp_enc, input logic [5:0] exp_par);
    exp_t e;
    data_in = d;
`ifdef HAMMING_ENC_ERR_INJECT_EN
    err_mask = m;
`else
    if (m != 32'd0) $display("note: err_mask ignored in this build");
`endif
    start = 1'b1;
    @(posedge clk);
    e.enc = exp_enc;
    e.par = exp_par;
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int at);
    bit found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        break;
      end
    end
    at = cyc;
    if (!found) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
    end
  endtask

`ifdef HAMMING_ENC_ERR_INJECT_EN
  function automatic logic [26:0] ref_decode(input logic [31:0] cw);
    logic [4:0]  syn;
    logic [25:0] d;
    logic        single;
    int          k;
    syn = '0;
    for (int i = 1; i < 32; i++) if (cw[i]) syn ^= i[4:0];
    single = (^cw) && (syn != 0);
    if (single) cw[syn] = ~cw[syn];
    k = 0;
    d = '0;
    for (int i = 1; i < 32; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[k] = cw[i];
        k++;
      end
    end
    return {single, d};
  endfunction
`endif

  initial begin
    int t0, t1, dc0;
    logic [31:0] cw;
    rst = 1'b1;
    start = 1'b0;
    data_in = '0;
`ifdef HAMMING_ENC_ERR_INJECT_EN
    err_mask = '0;
`endif

    vecs[0] = '{26'h0000001, 32'h0000000F, 6'h23};
    vecs[1] = '{26'h3FFFFFF, 32'hFFFFFFFF, 6'h3F};
    vecs[2] = '{26'h0000000, 32'h00000000, 6'h00};
    vecs[3] = '{26'h2AAAAAA, 32'h0, 6'h0};
    vecs[4] = '{26'h1555555, 32'h0, 6'h0};
    vecs[5] = '{26'h2000000, 32'h0, 6'h0};
    vecs[6] = '{26'h0000400, 32'h0, 6'h0};
    vecs[7] = '{26'($urandom), 32'h0, 6'h0};
    for (int i = 3; i < 8; i++) begin
      vecs[i].enc = model_cw(vecs[i].data);
      vecs[i].par = model_par(vecs[i].enc);
    end

    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_encoded", encoded_data, 32'd0);
    check("reset_parity", {26'd0, parity_bits}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      start_enc(vecs[i].data, 32'd0, vecs[i].enc, vecs[i].par);
      check("busy_in_load", {31'd0, busy}, 32'd1);
      wait_done("vector", t0);
      repeat (2) @(negedge clk);
      check("busy_after_done", {31'd0, busy}, 32'd0);
    end

    // Back-to-back: start raised during the DONE cycle.
    start_enc(26'h3FFFFFF, 32'd0, 32'hFFFFFFFF, 6'h3F);
    wait_done("b2b_first", t0);
    start_enc(26'h0, 32'd0, 32'h0, 6'h00);
    wait_done("b2b_second", t1);
    check("b2b_gap", t1 - t0, 8);
    repeat (3) @(negedge clk);

    // Starts while busy must be ignored, as must data_in changes.
    dc0 = done_count;
    cw = model_cw(26'h0ABCDEF);
    start_enc(26'h0ABCDEF, 32'd0, cw, model_par(cw));
    @(negedge clk);
    start = 1'b1;
    data_in = 26'h3000001;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    data_in = 26'h1234567;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_start", t0);
    repeat (12) @(negedge clk);
    check("ignore_single_done", done_count - dc0, 1);

    // Reset at acceptance+3 with start held high.
    dc0 = done_count;
    start_enc(26'h155AA55, 32'd0, 32'd0, 6'd0);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("midrst_encoded", encoded_data, 32'd0);
    check("midrst_parity", {26'd0, parity_bits}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    rst = 1'b0;
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_no_done", done_count - dc0, 0);

`ifdef HAMMING_ENC_ERR_INJECT_EN
    start_enc(26'h0000001, 32'h00000100, 32'h0000010F, 6'h23);
    wait_done("inject", t0);
    cw = encoded_data;
    check("inject_decode", {5'd0, ref_decode(cw)}, {5'd0, 1'b1, 26'h0000001});
    repeat (2) @(negedge clk);
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
